// File: rtl/four_12_12_st0_ctrl_pkg.sv
// Shared types and stage-0 geometry for the four_12_12 stage-0 controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package four_12_12_st0_ctrl_pkg;

  localparam int N_IN       = 12;  // inputs per neuron
  localparam int N_OUT      = 12;  // outputs per layer pass
  localparam int TAP_AW     = 5;
  localparam int BIAS_AW    = 4;
  localparam int DATA_AW    = 9;
  localparam int RD_LAT_DEF = 1;   // memory read latency
  localparam int IDX_W      = 4;   // width of k / o indices

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    LD_TAP  = 2'd0,
    LD_BIAS = 2'd1,
    LD_DATA = 2'd2,
    LD_ILL  = 2'd3
  } ld_sel_t;

  // MAC sideband travelling alongside the memory read data
  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [IDX_W-1:0] in_idx;
    logic [IDX_W-1:0] out_idx;
  } mac_sb_t;

endpackage

// File: rtl/four_12_12_st0_ctrl_pipe.sv
// Delay line that aligns MAC sideband with memory read data.
// Latency: DEPTH cycles from i_dat to o_dat.
// Backpressure: none; shifts every cycle, i_flush clears all stages at the next edge.
module four_12_12_st0_ctrl_pipe #(
  parameter int W     = 11,
  parameter int DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  logic [W-1:0] r_stage [DEPTH];

  // Shift one stage per cycle; a flush empties every stage at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/four_12_12_st0_ctrl.sv
// Stage-0 read sequencer and loader/port arbiter for tap, bias and data memories.
// Latency: first read 1 cycle after start, done N_IN*N_OUT+RD_LAT+1 cycles after start.
// Backpressure: loader is granted only in IDLE and never when start is high; reads are never stalled.
module four_12_12_st0_ctrl
  import four_12_12_st0_ctrl_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [DATA_AW-1:0] i_data_base,
  output logic               o_busy,
  output logic               o_done,
  input  logic               i_ld_valid,
  input  logic [1:0]         i_ld_sel,
  input  logic [DATA_AW-1:0] i_ld_addr,
  output logic               o_ld_ready,
  output logic               o_ld_err,
  output logic [TAP_AW-1:0]  o_tap_addr,
  output logic               o_tap_rd,
  output logic               o_tap_wr,
  output logic [BIAS_AW-1:0] o_bias_addr,
  output logic               o_bias_rd,
  output logic               o_bias_wr,
  output logic [DATA_AW-1:0] o_data_addr,
  output logic               o_data_rd,
  output logic               o_data_wr,
  output logic               o_mac_valid,
  output logic               o_mac_first,
  output logic               o_mac_last,
  output logic [IDX_W-1:0]   o_mac_in_idx,
  output logic [IDX_W-1:0]   o_mac_out_idx
);

  localparam int               DCNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(RD_LAT - 1);
  localparam logic [IDX_W-1:0]  LAST_K    = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0]  LAST_O    = IDX_W'(N_OUT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_o;
  logic [IDX_W-1:0]   r_k;
  logic [DATA_AW-1:0] r_daddr;   // running base + o*N_IN + k, wraps naturally
  logic [DCNT_W-1:0]  r_dcnt;
  logic               w_last_rd;
  logic               w_flush;
  mac_sb_t            w_sb;
  mac_sb_t            w_sb_q;

  assign w_last_rd = (r_o == LAST_O) && (r_k == LAST_K);
  assign w_flush   = i_abort && (r_state != ST_IDLE);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: abort wins in every busy state, start only counts in IDLE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_abort)        w_state_nxt = ST_IDLE;
        else if (w_last_rd) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_abort)                  w_state_nxt = ST_IDLE;
        else if (r_dcnt == DCNT_LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Walk k fastest, then o; address counter follows every issued read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_o     <= '0;
      r_k     <= '0;
      r_daddr <= '0;
      r_dcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dcnt <= '0;
          if (i_start) begin
            r_daddr <= i_data_base;
            r_o     <= '0;
            r_k     <= '0;
          end
        end
        ST_RUN: begin
          r_dcnt <= '0;
          if (i_abort || w_last_rd) begin
            r_o <= '0;
            r_k <= '0;
          end else begin
            r_daddr <= r_daddr + 1'b1;
            if (r_k == LAST_K) begin
              r_k <= '0;
              r_o <= r_o + 1'b1;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        ST_DRAIN: r_dcnt <= i_abort ? '0 : r_dcnt + 1'b1;
        default:  r_dcnt <= '0;
      endcase
    end
  end

  // Port drive: loader writes in IDLE, sequenced reads plus sideband in RUN
  always_comb begin
    o_ld_ready  = 1'b0;
    o_ld_err    = 1'b0;
    o_tap_addr  = '0;
    o_tap_rd    = 1'b0;
    o_tap_wr    = 1'b0;
    o_bias_addr = '0;
    o_bias_rd   = 1'b0;
    o_bias_wr   = 1'b0;
    o_data_addr = '0;
    o_data_rd   = 1'b0;
    o_data_wr   = 1'b0;
    w_sb        = '0;
    case (r_state)
      ST_IDLE: begin
        o_ld_ready = i_ld_valid & ~i_start;
        if (i_ld_valid && !i_start) begin
          case (i_ld_sel)
            LD_TAP: begin
              o_tap_wr   = 1'b1;
              o_tap_addr = i_ld_addr[TAP_AW-1:0];
            end
            LD_BIAS: begin
              o_bias_wr   = 1'b1;
              o_bias_addr = i_ld_addr[BIAS_AW-1:0];
            end
            LD_DATA: begin
              o_data_wr   = 1'b1;
              o_data_addr = i_ld_addr;
            end
            default: o_ld_err = 1'b1;  // illegal select: accepted and dropped
          endcase
        end
      end
      ST_RUN: begin
        o_data_rd   = 1'b1;
        o_data_addr = r_daddr;
        if (r_k == '0) begin
          o_tap_rd    = 1'b1;
          o_tap_addr  = TAP_AW'(r_o);
          o_bias_rd   = 1'b1;
          o_bias_addr = BIAS_AW'(r_o);
        end
        w_sb.valid   = 1'b1;
        w_sb.first   = (r_k == '0);
        w_sb.last    = (r_k == LAST_K);
        w_sb.in_idx  = r_k;
        w_sb.out_idx = r_o;
      end
      default: ;
    endcase
  end

  four_12_12_st0_ctrl_pipe #(
    .W     ($bits(mac_sb_t)),
    .DEPTH (RD_LAT)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_flush),
    .i_dat   (w_sb),
    .o_dat   (w_sb_q)
  );

  assign o_busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done        = (r_state == ST_DONE);
  assign o_mac_valid   = w_sb_q.valid;
  assign o_mac_first   = w_sb_q.first;
  assign o_mac_last    = w_sb_q.last;
  assign o_mac_in_idx  = w_sb_q.in_idx;
  assign o_mac_out_idx = w_sb_q.out_idx;

endmodule
